// File: rtl/ahb_s2m_nslv.sv
// ahb_s2m_nslv: AHB-Lite slave-to-master response mux with default slave and wait-state watchdog
module ahb_s2m_nslv #(
  parameter int NUM_S   = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                HRESETn,
  input  logic                HCLK,
  input  logic [NUM_S-1:0]    HSEL,
  input  logic [1:0]          HTRANS,
  input  logic [NUM_S*DW-1:0] HRDATA_S,
  input  logic [NUM_S*2-1:0]  HRESP_S,
  input  logic [NUM_S-1:0]    HREADY_S,
  output logic [DW-1:0]       HRDATA,
  output logic [1:0]          HRESP,
  output logic                HREADY,
  output logic                TOUT
);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {PASS, ERR1, ERR2} state_t;
  state_t           state, state_nx;
  logic [NUM_S-1:0] sel_reg;
  logic             act_reg;
  logic [WW-1:0]    wcnt;
  logic             valid, s_rdy, trip;
  logic [DW-1:0]    s_data;
  logic [1:0]       s_resp;
  logic             unused_ok;
  assign unused_ok = HTRANS[0];
  assign valid = $onehot(sel_reg);
  assign trip = TIMEOUT != 0 && valid && !s_rdy && 32'(wcnt) == TIMEOUT - 1;
  // OR-merge of selected slaves; only trusted when exactly one is selected
  always_comb begin
    s_data = '0;
    s_resp = '0;
    s_rdy  = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      s_data |= {DW{sel_reg[i]}} & HRDATA_S[i*DW +: DW];
      s_resp |= {2{sel_reg[i]}} & HRESP_S[i*2 +: 2];
      s_rdy  |= sel_reg[i] & HREADY_S[i];
    end
  end
  // response FSM: pass-through, or two-cycle ERROR for unmapped/multi-select/timeout
  always_comb begin
    state_nx = state;
    HRDATA   = '0;
    HRESP    = 2'b00;
    HREADY   = 1'b1;
    TOUT     = 1'b0;
    case (state)
      PASS: begin
        if (valid) begin
          HRDATA = s_data;
          HRESP  = s_resp;
          HREADY = s_rdy;
          if (trip) state_nx = ERR1;
        end else if (act_reg) begin
          HREADY   = 1'b0;
          HRESP    = 2'b01;
          state_nx = ERR2;
        end
      end
      ERR1: begin
        HREADY   = 1'b0;
        HRESP    = 2'b01;
        TOUT     = 1'b1;
        state_nx = ERR2;
      end
      ERR2: begin
        HRESP    = 2'b01;
        state_nx = PASS;
      end
      default: state_nx = PASS;
    endcase
  end
  // state, address-phase capture and wait-state counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= PASS;
      sel_reg <= '0;
      act_reg <= 1'b0;
      wcnt    <= '0;
    end else begin
      state <= state_nx;
      if (HREADY) begin
        sel_reg <= HSEL;
        act_reg <= HTRANS[1];
      end
      wcnt <= (HREADY || state != PASS || TIMEOUT == 0) ? '0 :
              (valid && !s_rdy) ? wcnt + 1'b1 : wcnt;
    end
  end
endmodule

// File: tb/tb_ahb_s2m_nslv.sv
// tb_ahb_s2m_nslv: directed self-checking bench for ahb_s2m_nslv (TIMEOUT=4 and TIMEOUT=0 instances)
module tb_ahb_s2m_nslv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  hsel = '0;
  logic [1:0]  htrans = '0;
  logic [95:0] hrdata_s = {32'hC2, 32'hB1, 32'hA0};
  logic [5:0]  hresp_s = '0;
  logic [2:0]  hready_s = 3'b111;
  logic [31:0] hrdata, z_hrdata;
  logic [1:0]  hresp, z_hresp;
  logic        hready, z_hready, tout, z_tout;
  logic [35:0] obs, obz;
  int checks = 0;
  int fails = 0;
  assign obs = {hready, hresp, tout, hrdata};
  assign obz = {z_hready, z_hresp, z_tout, z_hrdata};

  always #5 clk = ~clk;

  ahb_s2m_nslv #(.NUM_S(3), .DW(32), .TIMEOUT(4)) dut (
    .HRESETn(rst_n), .HCLK(clk), .HSEL(hsel), .HTRANS(htrans),
    .HRDATA_S(hrdata_s), .HRESP_S(hresp_s), .HREADY_S(hready_s),
    .HRDATA(hrdata), .HRESP(hresp), .HREADY(hready), .TOUT(tout));

  ahb_s2m_nslv #(.NUM_S(3), .DW(32), .TIMEOUT(0)) dut0 (
    .HRESETn(rst_n), .HCLK(clk), .HSEL(hsel), .HTRANS(htrans),
    .HRDATA_S(hrdata_s), .HRESP_S(hresp_s), .HREADY_S(hready_s),
    .HRDATA(z_hrdata), .HRESP(z_hresp), .HREADY(z_hready), .TOUT(z_tout));

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; hsel = '0; htrans = 2'b00; hready_s = 3'b111; hresp_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL reset_init: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
    rst_n = 1'b1;
    @(negedge clk);
    hsel = 3'b010; htrans = 2'b10;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hready_s = 3'b101; #1;
    checks++;
    if (obs !== {1'b0, 2'b00, 1'b0, 32'hB1}) begin fails++; $display("FAIL reset_prewait: got %h exp %h", obs, {1'b0, 2'b00, 1'b0, 32'hB1}); end
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL reset_async: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
    @(negedge clk);
    rst_n = 1'b1; hready_s = 3'b111;
    @(negedge clk);
    hsel = 3'b001; htrans = 2'b10;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'hA0}) begin fails++; $display("FAIL reset_first_xfer: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'hA0}); end
  endtask

  task automatic test_routing;
    logic [31:0] exp_d [3] = '{32'hA0, 32'hB1, 32'hC2};
    do_reset();
    hsel = 3'b001; htrans = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hsel = (i < 2) ? 3'(1 << (i + 1)) : 3'b000;
      htrans = (i < 2) ? 2'b10 : 2'b00; #1;
      checks++;
      if (obs !== {1'b1, 2'b00, 1'b0, exp_d[i]}) begin fails++; $display("FAIL route_s%0d: got %h exp %h", i, obs, {1'b1, 2'b00, 1'b0, exp_d[i]}); end
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL route_idle: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
  endtask

  task automatic test_default_err(input logic [2:0] sel, input logic [1:0] tr, input string nm);
    do_reset();
    hsel = sel; htrans = tr;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; #1;
    checks++;
    if (obs !== {1'b0, 2'b01, 1'b0, 32'h0}) begin fails++; $display("FAIL %s_c1: got %h exp %h", nm, obs, {1'b0, 2'b01, 1'b0, 32'h0}); end
    @(negedge clk);
    hsel = 3'b001; htrans = 2'b10; #1;
    checks++;
    if (obs !== {1'b1, 2'b01, 1'b0, 32'h0}) begin fails++; $display("FAIL %s_c2: got %h exp %h", nm, obs, {1'b1, 2'b01, 1'b0, 32'h0}); end
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'hA0}) begin fails++; $display("FAIL %s_b2b: got %h exp %h", nm, obs, {1'b1, 2'b00, 1'b0, 32'hA0}); end
  endtask

  task automatic test_unmapped_idle;
    do_reset();
    hsel = 3'b000; htrans = 2'b00;
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL unmapped_idle: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
  endtask

  task automatic test_watchdog(input bit late_ready);
    do_reset();
    hsel = 3'b010; htrans = 2'b10;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hready_s = 3'b101;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (obs !== {1'b0, 2'b00, 1'b0, 32'hB1}) begin fails++; $display("FAIL wd_wait%0d: got %h exp %h", c, obs, {1'b0, 2'b00, 1'b0, 32'hB1}); end
      @(negedge clk);
    end
    if (late_ready) begin
      hready_s = 3'b111; #1;
      checks++;
      if (obs !== {1'b1, 2'b00, 1'b0, 32'hB1}) begin fails++; $display("FAIL wd_late_done: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'hB1}); end
      @(negedge clk); #1;
      checks++;
      if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL wd_late_after: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
    end else begin
      #1;
      checks++;
      if (obs !== {1'b0, 2'b00, 1'b0, 32'hB1}) begin fails++; $display("FAIL wd_wait4: got %h exp %h", obs, {1'b0, 2'b00, 1'b0, 32'hB1}); end
      @(negedge clk); #1;
      checks++;
      if (obs !== {1'b0, 2'b01, 1'b1, 32'h0}) begin fails++; $display("FAIL wd_err1: got %h exp %h", obs, {1'b0, 2'b01, 1'b1, 32'h0}); end
      @(negedge clk); #1;
      checks++;
      if (obs !== {1'b1, 2'b01, 1'b0, 32'h0}) begin fails++; $display("FAIL wd_err2: got %h exp %h", obs, {1'b1, 2'b01, 1'b0, 32'h0}); end
      @(negedge clk); #1;
      checks++;
      if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL wd_after: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
    end
  endtask

  task automatic test_slave_error;
    do_reset();
    hsel = 3'b100; htrans = 2'b10;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hready_s = 3'b011; hresp_s = 6'b01_00_00; #1;
    checks++;
    if (obs !== {1'b0, 2'b01, 1'b0, 32'hC2}) begin fails++; $display("FAIL slverr_c1: got %h exp %h", obs, {1'b0, 2'b01, 1'b0, 32'hC2}); end
    @(negedge clk);
    hready_s = 3'b111; #1;
    checks++;
    if (obs !== {1'b1, 2'b01, 1'b0, 32'hC2}) begin fails++; $display("FAIL slverr_c2: got %h exp %h", obs, {1'b1, 2'b01, 1'b0, 32'hC2}); end
    @(negedge clk);
    hresp_s = '0; #1;
    checks++;
    if (obs !== {1'b1, 2'b00, 1'b0, 32'h0}) begin fails++; $display("FAIL slverr_after: got %h exp %h", obs, {1'b1, 2'b00, 1'b0, 32'h0}); end
  endtask

  task automatic test_timeout0;
    int bad = 0;
    do_reset();
    hsel = 3'b010; htrans = 2'b10;
    @(negedge clk);
    hsel = 3'b000; htrans = 2'b00; hready_s = 3'b101;
    for (int c = 0; c < 1000; c++) begin
      #1;
      if (obz !== {1'b0, 2'b00, 1'b0, 32'hB1}) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL t0_stall: got %0d bad cycles exp 0", bad); end
    hready_s = 3'b111; #1;
    checks++;
    if (obz !== {1'b1, 2'b00, 1'b0, 32'hB1}) begin fails++; $display("FAIL t0_done: got %h exp %h", obz, {1'b1, 2'b00, 1'b0, 32'hB1}); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_default_err(3'b000, 2'b10, "unmapped");
    test_default_err(3'b011, 2'b11, "multihot");
    test_unmapped_idle();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_slave_error();
    test_timeout0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ahb_s2m_nslv.md
# ahb_s2m_nslv

Parametrised AHB-Lite slave-to-master response multiplexer for an N-slave interconnect, sitting between the address decoder/slaves and the single master. It registers the decoder's one-hot select on each accepted address phase and routes the matching slave's HRDATA/HRESP/HREADY to the master. An integrated default slave answers unmapped or multi-select transfers with a two-cycle ERROR. A wait-state watchdog aborts transfers from a slave that stalls too long.

## Interface
- NUM_S, 3: number of slaves, 1..16
- DW, 32: data width, 32 or 64
- TIMEOUT, 256: max consecutive slave wait states before forced ERROR; 0 disables watchdog
- HRESETn  in  1  asynchronous, active-low reset
- HCLK  in  1  clock
- HSEL  in  NUM_S  one-hot slave select from decoder (address phase)
- HTRANS  in  2  master transfer type (address phase)
- HRDATA_S  in  NUM_S*DW  slave read data, slave i at [i*DW +: DW]
- HRESP_S  in  NUM_S*2  slave responses, slave i at [i*2 +: 2]
- HREADY_S  in  NUM_S  slave HREADYOUT
- HRDATA  out  DW  read data to master
- HRESP  out  2  response to master (00 OKAY, 01 ERROR)
- HREADY  out  1  ready to master and all slaves
- TOUT  out  1  one-cycle pulse when watchdog fires

## Operation
- Capture: when HREADY=1, sel_reg <= HSEL and act_reg <= HTRANS[1]; otherwise both hold.
- valid = sel_reg has exactly one bit set; invalid = act_reg & (sel_reg zero or multi-hot).
- FSM states: PASS, ERR1, ERR2. Reset state PASS.
- PASS, valid: HRDATA/HRESP/HREADY = selected slave's signals.
- PASS, sel_reg zero/multi-hot, act_reg=0: HREADY=1, HRESP=OKAY, HRDATA=0.
- PASS, invalid: HREADY=0, HRESP=ERROR, HRDATA=0. Next state ERR2.
- ERR1: HREADY=0, HRESP=ERROR, HRDATA=0, TOUT=1. Next state ERR2.
- ERR2: HREADY=1, HRESP=ERROR, HRDATA=0. The new address phase is captured. Next state PASS.
- Watchdog: wcnt width clog2(TIMEOUT+1). wcnt clears whenever HREADY=1 or state!=PASS. It increments in PASS when valid and the selected HREADY_S=0.
- Watchdog trip: if wcnt==TIMEOUT-1 and the selected HREADY_S=0 in PASS, next state is ERR1. A slave that returns HREADY_S=1 in that same cycle wins, and the transfer completes normally.
- After a trip, the slave sees HREADY=1 in ERR2. Its pending data phase is considered abandoned; recovery is the slave's concern.
- Slave ERROR responses (two-cycle, HREADY_S=0 then 1) pass through unmodified and do not count as a timeout unless they exceed TIMEOUT.
- No register updates occur on HRESETn low. Reset mid-transfer returns to PASS with sel_reg=0 immediately (asynchronous assertion).

## Timing
- Reset values: sel_reg=0, act_reg=0, wcnt=0, state PASS. Outputs: HREADY=1, HRESP=00, HRDATA=0, TOUT=0.
- Routing is combinational from registered state; zero-cycle latency from slave outputs to master outputs.
- Select latency: HSEL sampled at the edge ending the address phase. It is used throughout the following data phase.
- Unmapped access: exactly two data-phase cycles, (HREADY=0,ERROR) then (HREADY=1,ERROR).
- Timeout: master sees TIMEOUT wait cycles, then ERR1, then ERR2. The data phase totals TIMEOUT+2 cycles.
- HREADY=1 in ERR2 allows back-to-back pipelining. A transfer whose address phase coincides with ERR2 is captured normally.

## Test plan
- Reset: assert HRESETn=0 mid-wait → HREADY=1, HRESP=00, HRDATA=0, TOUT=0 immediately; after release, first transfer routes correctly.
- Routing: NUM_S=3, sequence of NONSEQ reads to slaves 0,1,2 with data 0xA0,0xB1,0xC2 and zero waits → HRDATA matches per data phase, HRESP=00, no bubble.
- Unmapped: HSEL=000, HTRANS=NONSEQ → data phase (0,01) then (1,01); HSEL=000 with HTRANS=IDLE → single (1,00).
- Multi-hot: HSEL=011, HTRANS=SEQ → two-cycle ERROR, no slave data leaked (HRDATA=0).
- Watchdog: TIMEOUT=4, slave 1 holds HREADY_S=0 → 4 wait cycles, TOUT pulse in cycle 5 with HREADY=0/ERROR, cycle 6 HREADY=1/ERROR. The same test with HREADY_S rising in cycle 4 → normal OKAY completion, TOUT=0.
- Slave ERROR passthrough and TIMEOUT=0: slave 2 returns two-cycle ERROR → passed through. With TIMEOUT=0, a 1000-cycle stall completes normally without TOUT.
